// File: rtl/msi_cache_assoc_pkg.sv
// Shared types for the two-way MSI cache: coherence block state and snoop opcode.
package common;

    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        SHARED   = 2'd1,
        MODIFIED = 2'd2
    } blk_state_t;

    typedef enum logic {
        SNP_READ = 1'b0,
        SNP_INV  = 1'b1
    } snp_op_t;

endpackage

// File: rtl/msi_cache_assoc_way.sv
// One way of the cache: resettable state array plus unreset tag/data arrays.
// A full-entry write port, a state-only port for snoop downgrades, two async read ports.
module msi_cache_way
    import common::*;
#(
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 5,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  blk_state_t        wstate,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [LINE_W-1:0] wdata,
    input  logic              su_en,
    input  logic [IDX_W-1:0]  su_addr,
    input  blk_state_t        su_state,
    input  logic [IDX_W-1:0]  ra_addr,
    output blk_state_t        ra_state,
    output logic [TAG_W-1:0]  ra_tag,
    output logic [LINE_W-1:0] ra_data,
    input  logic [IDX_W-1:0]  rb_addr,
    output blk_state_t        rb_state,
    output logic [TAG_W-1:0]  rb_tag,
    output logic [LINE_W-1:0] rb_data
);
    localparam int SETS = 1 << IDX_W;

    blk_state_t        state_q [SETS];
    blk_state_t        state_d [SETS];
    logic [TAG_W-1:0]  tag_mem [SETS];
    logic [LINE_W-1:0] data_mem [SETS];

    // The top never issues both ports to the same index in one cycle.
    always_comb begin
        state_d = state_q;
        if (su_en) state_d[su_addr] = su_state;
        if (we)    state_d[waddr]   = wstate;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SETS; i++) state_q[i] <= INVALID;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[waddr]  <= wtag;
            data_mem[waddr] <= wdata;
        end
    end

    assign ra_state = state_q[ra_addr];
    assign ra_tag   = tag_mem[ra_addr];
    assign ra_data  = data_mem[ra_addr];
    assign rb_state = state_q[rb_addr];
    assign rb_tag   = tag_mem[rb_addr];
    assign rb_data  = data_mem[rb_addr];

endmodule

// File: rtl/msi_cache_assoc.sv
// Two-way set-associative MSI cache with one CPU port and one snoop port.
// Lookups are single-cycle; all responses are registered and held until the next one.
module msi_cache_assoc
    import common::*;
#(
    parameter int ADDR_W = 11,
    parameter int IDX_W  = 6,
    parameter int LINE_W = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_re,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [LINE_W-1:0]       cpu_wdata,
    input  blk_state_t              cpu_wstate,
    output logic                    cpu_vld,
    output logic                    cpu_hit,
    output blk_state_t              cpu_rstate,
    output logic [LINE_W-1:0]       cpu_rdata,
    output logic                    cpu_retry,
    output logic                    evict_dirty,
    output logic [ADDR_W-IDX_W-1:0] evict_tag,
    output logic [LINE_W-1:0]       evict_data,
    input  logic                    snp_req,
    input  snp_op_t                 snp_op,
    input  logic [ADDR_W-1:0]       snp_addr,
    output logic                    snp_vld,
    output logic                    snp_hit,
    output blk_state_t              snp_state,
    output logic [LINE_W-1:0]       snp_data
);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int SETS  = 1 << IDX_W;

    logic [IDX_W-1:0] cpu_idx, snp_idx;
    logic [TAG_W-1:0] cpu_tag, snp_tag;
    assign cpu_idx = cpu_addr[IDX_W-1:0];
    assign cpu_tag = cpu_addr[ADDR_W-1:IDX_W];
    assign snp_idx = snp_addr[IDX_W-1:0];
    assign snp_tag = snp_addr[ADDR_W-1:IDX_W];

    blk_state_t        ra_state [2];
    blk_state_t        rb_state [2];
    logic [TAG_W-1:0]  ra_tag   [2];
    logic [TAG_W-1:0]  rb_tag   [2];
    logic [LINE_W-1:0] ra_data  [2];
    logic [LINE_W-1:0] rb_data  [2];
    logic [1:0]        cpu_way_hit, snp_way_hit, we_way, su_way;
    blk_state_t        su_state;

    assign su_state = (snp_op == SNP_INV) ? INVALID : SHARED;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign cpu_way_hit[gi] = (ra_state[gi] != INVALID) && (ra_tag[gi] == cpu_tag);
            assign snp_way_hit[gi] = (rb_state[gi] != INVALID) && (rb_tag[gi] == snp_tag);

            msi_cache_way #(.IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
                .clk      (clk),
                .rst_n    (rst_n),
                .we       (we_way[gi]),
                .waddr    (cpu_idx),
                .wstate   (cpu_wstate),
                .wtag     (cpu_tag),
                .wdata    (cpu_wdata),
                .su_en    (su_way[gi]),
                .su_addr  (snp_idx),
                .su_state (su_state),
                .ra_addr  (cpu_idx),
                .ra_state (ra_state[gi]),
                .ra_tag   (ra_tag[gi]),
                .ra_data  (ra_data[gi]),
                .rb_addr  (snp_idx),
                .rb_state (rb_state[gi]),
                .rb_tag   (rb_tag[gi]),
                .rb_data  (rb_data[gi])
            );
        end
    endgenerate

    logic              cpu_vld_q, cpu_vld_d, cpu_hit_q, cpu_hit_d, cpu_retry_q, cpu_retry_d;
    blk_state_t        cpu_rstate_q, cpu_rstate_d, snp_state_q, snp_state_d;
    logic [LINE_W-1:0] cpu_rdata_q, cpu_rdata_d, evict_data_q, evict_data_d;
    logic [LINE_W-1:0] snp_data_q, snp_data_d;
    logic              evict_dirty_q, evict_dirty_d;
    logic [TAG_W-1:0]  evict_tag_q, evict_tag_d;
    logic              snp_vld_q, snp_vld_d, snp_hit_q, snp_hit_d;
    logic [SETS-1:0]   lru_q, lru_d;

    logic cpu_drop, cpu_hit_c, hit_way, victim_way, tgt_way, snp_way;

    // A write colliding with a snoop on the same set is dropped so the snoop wins.
    assign cpu_drop  = cpu_we && snp_req && (snp_idx == cpu_idx);
    assign cpu_hit_c = |cpu_way_hit;
    assign hit_way   = !cpu_way_hit[0];
    assign snp_way   = !snp_way_hit[0];
    assign tgt_way   = cpu_hit_c ? hit_way : victim_way;

    always_comb begin
        if (ra_state[0] == INVALID)      victim_way = 1'b0;
        else if (ra_state[1] == INVALID) victim_way = 1'b1;
        else                             victim_way = lru_q[cpu_idx];
    end

    always_comb begin
        cpu_vld_d     = 1'b0;
        cpu_hit_d     = cpu_hit_q;
        cpu_retry_d   = cpu_retry_q;
        cpu_rstate_d  = cpu_rstate_q;
        cpu_rdata_d   = cpu_rdata_q;
        evict_dirty_d = evict_dirty_q;
        evict_tag_d   = evict_tag_q;
        evict_data_d  = evict_data_q;
        snp_vld_d     = 1'b0;
        snp_hit_d     = snp_hit_q;
        snp_state_d   = snp_state_q;
        snp_data_d    = snp_data_q;
        lru_d         = lru_q;
        we_way        = 2'b00;
        su_way        = 2'b00;

        if (cpu_re || cpu_we) begin
            cpu_vld_d     = 1'b1;
            cpu_retry_d   = cpu_drop;
            cpu_hit_d     = 1'b0;
            cpu_rstate_d  = INVALID;
            cpu_rdata_d   = '0;
            evict_dirty_d = 1'b0;
            evict_tag_d   = '0;
            evict_data_d  = '0;
            if (!cpu_drop) begin
                if (cpu_hit_c) begin
                    cpu_hit_d    = 1'b1;
                    cpu_rstate_d = ra_state[hit_way];
                    cpu_rdata_d  = ra_data[hit_way];
                end else if (ra_state[victim_way] != INVALID) begin
                    evict_dirty_d = (ra_state[victim_way] == MODIFIED);
                    evict_tag_d   = ra_tag[victim_way];
                    evict_data_d  = ra_data[victim_way];
                end
                if (cpu_we) begin
                    we_way[tgt_way] = 1'b1;
                    if (cpu_wstate != INVALID) lru_d[cpu_idx] = ~tgt_way;
                end else if (cpu_hit_c) begin
                    lru_d[cpu_idx] = ~hit_way;
                end
            end
        end

        if (snp_req) begin
            snp_vld_d   = 1'b1;
            snp_hit_d   = |snp_way_hit;
            snp_state_d = INVALID;
            snp_data_d  = '0;
            if (|snp_way_hit) begin
                snp_state_d = rb_state[snp_way];
                snp_data_d  = rb_data[snp_way];
                if (snp_op == SNP_INV || rb_state[snp_way] == MODIFIED) su_way[snp_way] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_vld_q     <= 1'b0;
            cpu_hit_q     <= 1'b0;
            cpu_retry_q   <= 1'b0;
            cpu_rstate_q  <= INVALID;
            cpu_rdata_q   <= '0;
            evict_dirty_q <= 1'b0;
            evict_tag_q   <= '0;
            evict_data_q  <= '0;
            snp_vld_q     <= 1'b0;
            snp_hit_q     <= 1'b0;
            snp_state_q   <= INVALID;
            snp_data_q    <= '0;
            lru_q         <= '0;
        end else begin
            cpu_vld_q     <= cpu_vld_d;
            cpu_hit_q     <= cpu_hit_d;
            cpu_retry_q   <= cpu_retry_d;
            cpu_rstate_q  <= cpu_rstate_d;
            cpu_rdata_q   <= cpu_rdata_d;
            evict_dirty_q <= evict_dirty_d;
            evict_tag_q   <= evict_tag_d;
            evict_data_q  <= evict_data_d;
            snp_vld_q     <= snp_vld_d;
            snp_hit_q     <= snp_hit_d;
            snp_state_q   <= snp_state_d;
            snp_data_q    <= snp_data_d;
            lru_q         <= lru_d;
        end
    end

    assign cpu_vld     = cpu_vld_q;
    assign cpu_hit     = cpu_hit_q;
    assign cpu_retry   = cpu_retry_q;
    assign cpu_rstate  = cpu_rstate_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign evict_dirty = evict_dirty_q;
    assign evict_tag   = evict_tag_q;
    assign evict_data  = evict_data_q;
    assign snp_vld     = snp_vld_q;
    assign snp_hit     = snp_hit_q;
    assign snp_state   = snp_state_q;
    assign snp_data    = snp_data_q;

endmodule

// File: tb/tb_msi_cache_assoc.sv
// Directed self-checking bench for msi_cache_assoc; one line per checked transaction.
module tb_msi_cache_assoc;
    import common::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_re = 1'b0, cpu_we = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [63:0] cpu_wdata = '0;
    blk_state_t  cpu_wstate = INVALID;
    logic        cpu_vld, cpu_hit, cpu_retry, evict_dirty;
    blk_state_t  cpu_rstate, snp_state;
    logic [63:0] cpu_rdata, evict_data, snp_data;
    logic [4:0]  evict_tag;
    logic        snp_req = 1'b0;
    snp_op_t     snp_op = SNP_READ;
    logic [10:0] snp_addr = '0;
    logic        snp_vld, snp_hit;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] DA = 64'hAAAA_0000_0000_0040;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_0080;
    localparam logic [63:0] DC = 64'hCCCC_0000_0000_00C0;
    localparam logic [63:0] DD = 64'hDDDD_0000_0000_0001;
    localparam logic [63:0] DE = 64'hEEEE_0000_0000_0085;
    localparam logic [63:0] DF = 64'hFFFF_0000_0000_003F;

    msi_cache_assoc dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstate(cpu_wstate),
        .cpu_vld(cpu_vld), .cpu_hit(cpu_hit), .cpu_rstate(cpu_rstate),
        .cpu_rdata(cpu_rdata), .cpu_retry(cpu_retry),
        .evict_dirty(evict_dirty), .evict_tag(evict_tag), .evict_data(evict_data),
        .snp_req(snp_req), .snp_op(snp_op), .snp_addr(snp_addr),
        .snp_vld(snp_vld), .snp_hit(snp_hit), .snp_state(snp_state), .snp_data(snp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of stimulus; outputs are sampled 1 ns after the edge.
    task automatic step(input logic re, input logic we, input logic [10:0] a,
                        input logic [63:0] d, input blk_state_t ws,
                        input logic sr, input snp_op_t so, input logic [10:0] sa);
        cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wstate = ws;
        snp_req = sr; snp_op = so; snp_addr = sa;
        @(posedge clk);
        #1;
        cpu_re = 1'b0; cpu_we = 1'b0; snp_req = 1'b0;
        $display("txn re=%0b we=%0b addr=0x%03h snp=%0b op=%0d saddr=0x%03h -> vld=%0b hit=%0b st=%0d retry=%0b ev_d=%0b ev_t=0x%0h | svld=%0b shit=%0b sst=%0d",
                 re, we, a, sr, so, sa, cpu_vld, cpu_hit, cpu_rstate, cpu_retry,
                 evict_dirty, evict_tag, snp_vld, snp_hit, snp_state);
    endtask

    task automatic rd(input logic [10:0] a);
        step(1'b1, 1'b0, a, '0, INVALID, 1'b0, SNP_READ, '0);
    endtask

    task automatic wr(input logic [10:0] a, input logic [63:0] d, input blk_state_t s);
        step(1'b0, 1'b1, a, d, s, 1'b0, SNP_READ, '0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, INVALID, 1'b0, SNP_READ, '0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_vld", cpu_vld, 0);
        check("rst_cpu_rstate", cpu_rstate, INVALID);
        check("rst_snp_vld", snp_vld, 0);
        rst_n = 1'b1;

        rd(11'h7FF);
        check("r7ff_vld", cpu_vld, 1);
        check("r7ff_hit", cpu_hit, 0);
        check("r7ff_state", cpu_rstate, INVALID);
        check("r7ff_dirty", evict_dirty, 0);
        check("r7ff_retry", cpu_retry, 0);
        idle();
        check("idle_vld", cpu_vld, 0);

        wr(11'h040, DA, MODIFIED);
        check("w040_vld", cpu_vld, 1);
        check("w040_hit", cpu_hit, 0);
        wr(11'h080, DB, SHARED);
        rd(11'h040);
        check("r040_hit", cpu_hit, 1);
        check("r040_state", cpu_rstate, MODIFIED);
        check("r040_data", cpu_rdata, DA);
        idle();
        check("hold_rdata", cpu_rdata, DA);
        rd(11'h0C0);
        check("r0c0_hit", cpu_hit, 0);
        check("r0c0_state", cpu_rstate, INVALID);
        check("r0c0_evtag", evict_tag, 5'h02);
        check("r0c0_evdirty", evict_dirty, 0);
        check("r0c0_evdata", evict_data, DB);

        wr(11'h0C0, DC, SHARED);
        check("w0c0_hit", cpu_hit, 0);
        rd(11'h080);
        check("r080_miss", cpu_hit, 0);
        check("r080_evdirty", evict_dirty, 1);
        check("r080_evtag", evict_tag, 5'h01);
        check("r080_evdata", evict_data, DA);
        rd(11'h040);
        check("r040b_hit", cpu_hit, 1);
        rd(11'h0C0);
        check("r0c0b_data", cpu_rdata, DC);

        step(1'b0, 1'b0, '0, '0, INVALID, 1'b1, SNP_READ, 11'h040);
        check("sr040_vld", snp_vld, 1);
        check("sr040_hit", snp_hit, 1);
        check("sr040_state", snp_state, MODIFIED);
        check("sr040_data", snp_data, DA);
        check("sr040_cpuvld", cpu_vld, 0);
        rd(11'h040);
        check("r040_shared", cpu_rstate, SHARED);

        step(1'b0, 1'b1, 11'h001, DD, SHARED, 1'b1, SNP_INV, 11'h040);
        check("si040_vld", snp_vld, 1);
        check("si040_state", snp_state, SHARED);
        check("w001_vld", cpu_vld, 1);
        check("w001_retry", cpu_retry, 0);
        rd(11'h040);
        check("r040_inv", cpu_hit, 0);
        rd(11'h001);
        check("r001_hit", cpu_hit, 1);
        check("r001_data", cpu_rdata, DD);

        step(1'b0, 1'b1, 11'h085, DE, MODIFIED, 1'b1, SNP_INV, 11'h045);
        check("si045_hit", snp_hit, 0);
        check("si045_state", snp_state, INVALID);
        check("si045_data", snp_data, 0);
        check("w085_vld", cpu_vld, 1);
        check("w085_retry", cpu_retry, 1);
        check("w085_hit", cpu_hit, 0);
        rd(11'h085);
        check("r085_miss", cpu_hit, 0);
        check("r085_retry", cpu_retry, 0);
        wr(11'h085, DE, MODIFIED);
        check("w085b_retry", cpu_retry, 0);
        rd(11'h085);
        check("r085_hit", cpu_hit, 1);
        check("r085_data", cpu_rdata, DE);

        wr(11'h03F, DF, MODIFIED);
        rd(11'h000);
        check("r000_miss", cpu_hit, 0);
        rd(11'h03F);
        check("r03f_hit", cpu_hit, 1);
        check("r03f_data", cpu_rdata, DF);
        wr(11'h03F, DF, INVALID);
        check("w03f_inv_hit", cpu_hit, 1);
        rd(11'h03F);
        check("r03f_gone", cpu_hit, 0);

        // Reset asserted while a request is being presented.
        cpu_re = 1'b1; cpu_addr = 11'h001;
        #2 rst_n = 1'b0;
        #1 cpu_re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_cpu_vld", cpu_vld, 0);
        check("rst2_rdata", cpu_rdata, 0);
        rst_n = 1'b1;
        idle();
        check("post_rst_vld", cpu_vld, 0);
        check("post_rst_svld", snp_vld, 0);
        rd(11'h001);
        check("post_rst_miss", cpu_hit, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msi_cache_assoc.md
MSI_CACHE_ASSOC -- requirements
Module: msi_cache_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, line address width (word-offset LSBs already dropped).
REQ-002 SHALL have parameter IDX_W, default 6, set index width; sets = 2**IDX_W; TAG_W = ADDR_W-IDX_W.
REQ-003 SHALL have parameter LINE_W, default 64, cache line width.
REQ-004 SHALL have ports:
clk  in  1  single clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
cpu_re  in  1  lookup request
cpu_we  in  1  write/fill request
cpu_addr  in  ADDR_W  line address {tag,index}
cpu_wdata  in  LINE_W  line to write
cpu_wstate  in  blk_state_t  state to write
cpu_vld  out  1  response valid
cpu_hit  out  1  tag match on non-INVALID way
cpu_rstate  out  blk_state_t  state of hit way
cpu_rdata  out  LINE_W  data of hit way
cpu_retry  out  1  request dropped, reissue
evict_dirty  out  1  victim way is MODIFIED
evict_tag  out  TAG_W  victim tag
evict_data  out  LINE_W  victim data
snp_req  in  1  snoop from other core
snp_op  in  snp_op_t  SNP_READ or SNP_INV
snp_addr  in  ADDR_W  snooped line address
snp_vld  out  1  snoop response valid
snp_hit  out  1  snooped line present
snp_state  out  blk_state_t  state before snoop action
snp_data  out  LINE_W  snooped line data

Function
REQ-005 SHALL be 2-way set associative; each way entry = {blk_state_t, tag, data}; one LRU bit per set (0 = way0 least recent).
REQ-006 cpu_vld SHALL assert exactly one cycle after any accepted cpu_re or cpu_we; all cpu_*/evict_* outputs registered, held until next response.
REQ-007 cpu_we with cpu_re SHALL be treated as a write; cpu_hit reports the pre-write lookup.
REQ-008 Read hit: cpu_hit=1, cpu_rstate/cpu_rdata from hit way; LRU set to point at the other way.
REQ-009 Read miss: cpu_hit=0, cpu_rstate=INVALID; evict_* describe victim; no array or LRU change.
REQ-010 Victim selection: first INVALID way (way0 before way1), else the LRU way.
REQ-011 Write: if tag hits a valid way, overwrite that way; else overwrite victim way per REQ-010; entry <= {cpu_wstate, tag, cpu_wdata}; LRU updated as REQ-008.
REQ-012 Write with cpu_wstate=INVALID SHALL invalidate the target way and leave LRU unchanged.
REQ-013 Snoop: snp_vld one cycle after snp_req; snp_hit/snp_state/snp_data reflect pre-action contents; miss gives snp_state=INVALID, snp_data=0.
REQ-014 SNP_READ hit on MODIFIED SHALL downgrade to SHARED; SHARED unchanged.
REQ-015 SNP_INV hit SHALL set the way INVALID; tag/data untouched; LRU unchanged.
REQ-016 Snoop has priority: cpu_we in the same cycle as snp_req to the same index SHALL be dropped; cpu_vld=1, cpu_retry=1, cpu_hit=0 next cycle.
REQ-017 Snoop and CPU to different indices in the same cycle SHALL both complete with no retry; cpu_re alone never retries.
REQ-018 cpu_retry SHALL be 0 on every response not covered by REQ-016.
REQ-019 Index wrap: all 2**IDX_W sets addressable; no aliasing between index 0 and max.

Reset
REQ-020 rst_n low SHALL asynchronously set every way state INVALID, all LRU bits 0, all outputs 0 (state outputs INVALID).
REQ-021 Tag/data arrays SHALL NOT be reset.
REQ-022 A request in flight when reset asserts SHALL be discarded; no cpu_vld/snp_vld after release until a new request.

Structure
REQ-023 blk_state_t (INVALID, SHARED, MODIFIED) and new snp_op_t (SNP_READ, SNP_INV) SHALL reside in package common.
REQ-024 One sub-module msi_cache_way (state/tag/data array for a single way, 1 write port, 2 read ports) SHALL be instantiated twice.

Verification
REQ-025 Reset, cpu_re addr 0x7FF -> cpu_vld=1, cpu_hit=0, cpu_rstate=INVALID, evict_dirty=0.
REQ-026 Write 0x040 MODIFIED data A, write 0x080 SHARED data B (same index 0), read 0x040 -> hit, MODIFIED, A; read 0x0C0 -> miss, evict_tag=0x02, evict_dirty=0 (LRU way1).
REQ-027 Third write 0x0C0 after REQ-026 reads -> replaces 0x080; read 0x080 misses, 0x040 still hits.
REQ-028 Line 0x040 MODIFIED, SNP_READ 0x040 -> snp_hit=1, snp_state=MODIFIED, snp_data=A; then cpu_re 0x040 -> SHARED.
REQ-029 SNP_INV 0x040 with same-cycle cpu_we 0x001 (index 1) -> both complete, no retry; cpu_re 0x040 -> miss.
REQ-030 snp_req SNP_INV 0x045 with same-cycle cpu_we 0x085 -> cpu_retry=1, array unchanged for 0x085; reissued write succeeds.
